axi4lite_regfile_slave: RTL and testbench

Parametrised AXI4-Lite slave register file. It is the next generation of the fixed 2-bit-address, 8-bit-data AXI4-Lite block.
Adds independent AW/W acceptance in either order, byte write strobes, configurable register count, hardware read-only registers and SLVERR responses.
Sits between the AXI4-Lite master/pin adapter and user logic. Exposes every register as a flat bus plus per-register write pulses.

---
 rtl/axi4lite_pkg.sv | 28 ++
 rtl/axi4lite_reg_bank.sv | 75 +++++++
 rtl/axi4lite_regfile_slave.sv | 168 ++++++++++++++++
 tb/tb_axi4lite_regfile_slave.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared response codes, channel state types and the byte-lane merge helper
// for the AXI4-Lite register file slave.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic [7:0] strb_merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/axi4lite_reg_bank.sv
// Register storage with byte-strobe merge, read-only slots fed from hw_in,
// one-cycle write pulses and the combinational read mux.
module axi4lite_reg_bank
    import axi4lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 3,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 6,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = 6'b100000,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    output logic                           wr_ok,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_ok,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] slot [NUM_REGS];

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            slot[i] = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
        end
    end

    // Addresses past NUM_REGS match no slot, so they fall out as errors here.
    always_comb begin
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
                wr_ok = 1'b1;
            end
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_ok   = 1'b1;
                rd_data = slot[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_ok && wr_addr == ADDR_WIDTH'(i)) begin
                    wr_pulse[i] <= 1'b1;
                    for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                        regs[i][b*8 +: 8] <= strb_merge_byte(regs[i][b*8 +: 8],
                                                             wr_data[b*8 +: 8],
                                                             wr_strb[b]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave front end: independent write (AW/W in any order) and read
// channel FSMs driving a parametrised register bank.
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 3,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 6,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = 6'b100000,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                    ready_en;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_hs, w_hs, ar_hs;
    logic                    commit, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data, rd_data;
    logic [DATA_WIDTH/8-1:0] c_strb;

    // ready_en keeps every ready low until the first edge after reset release.
    assign awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_D);
    assign wready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_A);
    assign bvalid  = (w_state == W_RESP);
    assign arready = ready_en && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // The commit takes whichever half arrives live on this edge, the other from the latch.
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        c_addr = aw_addr_q;
        c_data = wdata_q;
        c_strb = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                    c_addr = awaddr;
                    c_data = wdata;
                    c_strb = wstrb;
                end else if (aw_hs) begin
                    w_next = W_HAVE_A;
                end else if (w_hs) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                    c_data = wdata;
                    c_strb = wstrb;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                    c_addr = awaddr;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)  r_next = R_DATA;
            R_DATA:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp     <= RESP_OKAY;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_next;
            r_state  <= r_next;
            if (aw_hs) begin
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (ar_hs) begin
                rdata <= rd_data;
                rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axi4lite_reg_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK),
        .RESET_VAL  (RESET_VAL)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (commit),
        .wr_addr  (c_addr),
        .wr_data  (c_data),
        .wr_strb  (c_strb),
        .wr_ok    (wr_ok),
        .rd_addr  (araddr),
        .rd_data  (rd_data),
        .rd_ok    (rd_ok),
        .hw_in    (hw_in),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Self-checking bench for axi4lite_regfile_slave: directed scenarios plus
// randomized traffic checked against an array-based register model.
module tb_axi4lite_regfile_slave;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NR = 6;
  localparam int SW = DW / 8;
  localparam logic [NR-1:0] RO = 6'b100000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    awaddr = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [DW-1:0]    wdata = '0;
  logic [SW-1:0]    wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [AW-1:0]    araddr = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [NR*DW-1:0] hw_in = '0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    wr_pulse;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [NR];

  always #5 clk = ~clk;

  axi4lite_regfile_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO),
    .RESET_VAL  ('0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .hw_in    (hw_in),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int unsigned k = 0; k < SW; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic bit writable(input logic [AW-1:0] a);
    bit r;
    r = 1'b0;
    for (int unsigned i = 0; i < NR; i++) if (a == AW'(i) && !RO[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] exp_reg_q();
    logic [NR*DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NR; i++) if (!RO[i]) r[i*DW +: DW] = model[i];
    return r;
  endfunction

  function automatic void exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                   output logic [1:0] r);
    d = '0;
    r = 2'b10;
    for (int unsigned i = 0; i < NR; i++) begin
      if (a == AW'(i)) begin
        r = 2'b00;
        d = RO[i] ? hw_in[i*DW +: DW] : model[i];
      end
    end
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse_or,
                           output int pulse_cyc, output int b_wait, output bit stable,
                           output bit rdy_in_resp, output bit to);
    bit aw_go, w_go, b_go, aw_done, w_done, seen_b;
    int commit_t, bcnt;
    aw_go = 0; w_go = 0; b_go = 0; aw_done = 0; w_done = 0; seen_b = 0;
    commit_t = -1; bcnt = 0;
    resp = '0; pulse_or = '0; pulse_cyc = 0; b_wait = -1; stable = 1; rdy_in_resp = 0; to = 1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      if (aw_done && w_done && commit_t < 0) commit_t = t;
      if (b_go) begin
        to = 0;
        break;
      end
      #1;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && t >= aw_dly;
      wvalid  = !w_done && t >= w_dly;
      bready  = seen_b ? (bcnt >= b_dly) : (b_dly == 0);
      @(negedge clk);
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      if (wr_pulse !== '0) begin
        pulse_cyc++;
        pulse_or |= wr_pulse;
      end
      if (bvalid) begin
        if (!seen_b) begin
          seen_b = 1;
          resp   = bresp;
          b_wait = t - commit_t;
        end else if (bresp !== resp) begin
          stable = 0;
        end
        if (awready || wready) rdy_in_resp = 1;
        bcnt++;
        b_go = bready;
      end
    end
    #1;
    awvalid = 0;
    wvalid  = 0;
    bready  = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                          output logic [DW-1:0] data, output logic [1:0] resp,
                          output bit stable, output bit to);
    bit ar_go, ar_done, r_go, seen_r;
    int rcnt;
    ar_go = 0; ar_done = 0; r_go = 0; seen_r = 0; rcnt = 0;
    data = '0; resp = '0; stable = 1; to = 1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (ar_go) ar_done = 1;
      if (r_go) begin
        to = 0;
        break;
      end
      #1;
      araddr  = a;
      arvalid = !ar_done && t >= ar_dly;
      rready  = seen_r ? (rcnt >= r_dly) : (r_dly == 0);
      @(negedge clk);
      ar_go = arvalid && arready;
      if (rvalid) begin
        if (!seen_r) begin
          seen_r = 1;
          data   = rdata;
          resp   = rresp;
        end else if (rdata !== data || rresp !== resp) begin
          stable = 0;
        end
        rcnt++;
        r_go = rready;
      end
    end
    #1;
    arvalid = 0;
    rready  = 0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      $display("FAIL reset_handshakes got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
      bad++;
    end
    total++;
    if ({bresp, rresp, rdata, wr_pulse} !== '0) begin
      $display("FAIL reset_outputs bresp=%b rresp=%b rdata=%h pulse=%b want all 0", bresp, rresp, rdata, wr_pulse);
      bad++;
    end
    total++;
    if (reg_q !== exp_reg_q()) begin
      $display("FAIL reset_reg_q got=%h want=%h", reg_q, exp_reg_q());
      bad++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      $display("FAIL ready_before_first_edge got=%b want=000", {awready, wready, arready});
      bad++;
    end
    @(posedge clk);
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      $display("FAIL ready_after_first_edge got=%b want=111", {awready, wready, arready});
      bad++;
    end
  endtask

  task automatic test_same_cycle;
    logic [1:0] resp; logic [NR-1:0] por; int pc, bw; bit st, air, to; logic [DW-1:0] rd;
    axi_write(3'd2, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, por, pc, bw, st, air, to);
    model[2] = merge(model[2], 32'hDEADBEEF, 4'hF);
    total++;
    if (to !== 1'b0) begin
      $display("FAIL same_cycle_timeout got=%0d want=0", to);
      bad++;
    end
    total++;
    if (resp !== 2'b00 || bw !== 0) begin
      $display("FAIL same_cycle_b resp=%b wait=%0d want 00/0", resp, bw);
      bad++;
    end
    total++;
    if (por !== 6'b000100 || pc !== 1) begin
      $display("FAIL same_cycle_pulse got=%b x%0d want=000100 x1", por, pc);
      bad++;
    end
    total++;
    if (reg_q[2*DW +: DW] !== 32'hDEADBEEF) begin
      $display("FAIL same_cycle_reg_q got=%h want=deadbeef", reg_q[2*DW +: DW]);
      bad++;
    end
    axi_read(3'd2, 0, 0, rd, resp, st, to);
    total++;
    if (to !== 1'b0 || rd !== 32'hDEADBEEF || resp !== 2'b00) begin
      $display("FAIL same_cycle_read got=%h/%b to=%0d want=deadbeef/00", rd, resp, to);
      bad++;
    end
  endtask

  task automatic test_partial_strobe;
    logic [1:0] resp; logic [NR-1:0] por; int pc, bw; bit st, air, to; logic [DW-1:0] rd;
    axi_write(3'd2, 32'h11223344, 4'b0101, 0, 0, 0, resp, por, pc, bw, st, air, to);
    model[2] = merge(model[2], 32'h11223344, 4'b0101);
    axi_read(3'd2, 0, 0, rd, resp, st, to);
    total++;
    if (rd !== 32'hDE22BE44 || resp !== 2'b00) begin
      $display("FAIL partial_strobe got=%h/%b want=de22be44/00", rd, resp);
      bad++;
    end
  endtask

  task automatic test_split_order;
    logic [1:0] resp; logic [NR-1:0] por; int pc, bw; bit st, air, to;
    axi_write(3'd3, 32'hA5A5_0F0F, 4'hF, 0, 3, 4, resp, por, pc, bw, st, air, to);
    model[3] = merge(model[3], 32'hA5A5_0F0F, 4'hF);
    total++;
    if (to !== 1'b0 || resp !== 2'b00 || st !== 1'b1) begin
      $display("FAIL aw_first_b to=%0d resp=%b stable=%0d want 0/00/1", to, resp, st);
      bad++;
    end
    total++;
    if (por !== 6'b001000 || pc !== 1) begin
      $display("FAIL aw_first_pulse got=%b x%0d want=001000 x1", por, pc);
      bad++;
    end
    total++;
    if (air !== 1'b0 || awready !== 1'b1) begin
      $display("FAIL aw_first_ready in_resp=%0d after=%0d want 0/1", air, awready);
      bad++;
    end
    total++;
    if (reg_q !== exp_reg_q()) begin
      $display("FAIL aw_first_reg_q got=%h want=%h", reg_q, exp_reg_q());
      bad++;
    end
    axi_write(3'd4, 32'h0BAD_F00D, 4'b1100, 3, 0, 2, resp, por, pc, bw, st, air, to);
    model[4] = merge(model[4], 32'h0BAD_F00D, 4'b1100);
    total++;
    if (to !== 1'b0 || resp !== 2'b00 || por !== 6'b010000 || pc !== 1 || st !== 1'b1) begin
      $display("FAIL w_first resp=%b pulse=%b x%0d stable=%0d want 00/010000 x1/1", resp, por, pc, st);
      bad++;
    end
    total++;
    if (reg_q !== exp_reg_q()) begin
      $display("FAIL w_first_reg_q got=%h want=%h", reg_q, exp_reg_q());
      bad++;
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp; logic [NR-1:0] por; int pc, bw; bit st, air, to; logic [DW-1:0] rd;
    axi_write(3'd6, 32'h1234_5678, 4'hF, 0, 0, 0, resp, por, pc, bw, st, air, to);
    total++;
    if (resp !== 2'b10 || por !== '0 || pc !== 0) begin
      $display("FAIL err_oob_write resp=%b pulse=%b want 10/000000", resp, por);
      bad++;
    end
    total++;
    if (reg_q !== exp_reg_q()) begin
      $display("FAIL err_oob_reg_q got=%h want=%h", reg_q, exp_reg_q());
      bad++;
    end
    axi_write(3'd5, 32'h8765_4321, 4'hF, 1, 0, 0, resp, por, pc, bw, st, air, to);
    total++;
    if (resp !== 2'b10 || por !== '0) begin
      $display("FAIL err_ro_write resp=%b pulse=%b want 10/000000", resp, por);
      bad++;
    end
    hw_in[5*DW +: DW] = 32'hCAFE0001;
    axi_read(3'd5, 0, 0, rd, resp, st, to);
    total++;
    if (rd !== 32'hCAFE0001 || resp !== 2'b00) begin
      $display("FAIL ro_read got=%h/%b want=cafe0001/00", rd, resp);
      bad++;
    end
    axi_read(3'd7, 0, 2, rd, resp, st, to);
    total++;
    if (rd !== '0 || resp !== 2'b10 || st !== 1'b1) begin
      $display("FAIL err_oob_read got=%h/%b stable=%0d want=0/10/1", rd, resp, st);
      bad++;
    end
  endtask

  task automatic test_collision;
    logic [1:0] resp, rresp_v; logic [NR-1:0] por; int pc, bw; bit st, rst_v, air, to, rto;
    logic [DW-1:0] rd;
    axi_write(3'd1, 32'h1, 4'hF, 0, 0, 0, resp, por, pc, bw, st, air, to);
    model[1] = 32'h1;
    fork
      axi_write(3'd1, 32'h2, 4'hF, 0, 0, 0, resp, por, pc, bw, st, air, to);
      axi_read(3'd1, 0, 0, rd, rresp_v, rst_v, rto);
    join
    model[1] = 32'h2;
    total++;
    if (rd !== 32'h1 || rresp_v !== 2'b00 || rto !== 1'b0) begin
      $display("FAIL collision_old got=%h/%b want=00000001/00", rd, rresp_v);
      bad++;
    end
    axi_read(3'd1, 0, 0, rd, rresp_v, rst_v, rto);
    total++;
    if (rd !== 32'h2) begin
      $display("FAIL collision_new got=%h want=00000002", rd);
      bad++;
    end
  endtask

  task automatic test_random;
    logic [1:0] resp, er; logic [NR-1:0] por, ep; int pc, bw; bit st, air, to;
    logic [DW-1:0] rd, ed, d; logic [AW-1:0] a; logic [SW-1:0] s;
    for (int unsigned n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) hw_in[5*DW +: DW] = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom;
        s = SW'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  resp, por, pc, bw, st, air, to);
        ep = writable(a) ? (NR'(1) << a) : '0;
        if (writable(a)) model[a] = merge(model[a], d, s);
        total++;
        if (to !== 1'b0 || resp !== (writable(a) ? 2'b00 : 2'b10) || por !== ep
            || pc !== (writable(a) ? 1 : 0) || st !== 1'b1 || air !== 1'b0) begin
          $display("FAIL rand_write a=%0d resp=%b pulse=%b x%0d want pulse=%b", a, resp, por, pc, ep);
          bad++;
        end
        total++;
        if (reg_q !== exp_reg_q()) begin
          $display("FAIL rand_reg_q a=%0d got=%h want=%h", a, reg_q, exp_reg_q());
          bad++;
        end
      end else begin
        exp_read(a, ed, er);
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp, st, to);
        total++;
        if (to !== 1'b0 || rd !== ed || resp !== er || st !== 1'b1) begin
          $display("FAIL rand_read a=%0d got=%h/%b want=%h/%b", a, rd, resp, ed, er);
          bad++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [1:0] resp; logic [NR-1:0] por; int pc, bw, stray; bit st, air, to; logic [DW-1:0] rd;
    @(posedge clk);
    #1;
    awaddr = '0; wdata = 32'h5555_AAAA; wstrb = '1; awvalid = 1; wvalid = 1;
    araddr = 3'd2; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    total++;
    if ({bvalid, rvalid, wr_pulse} !== {2'b11, 6'b000001}) begin
      $display("FAIL pre_reset_state got=%b want=11000001", {bvalid, rvalid, wr_pulse});
      bad++;
    end
    #2;
    rst_n = 0;
    #1;
    for (int unsigned i = 0; i < NR; i++) model[i] = '0;
    total++;
    if ({bvalid, rvalid, awready, arready, wr_pulse, rdata} !== '0) begin
      $display("FAIL async_reset bvalid=%b rvalid=%b pulse=%b rdata=%h want all 0", bvalid, rvalid, wr_pulse, rdata);
      bad++;
    end
    total++;
    if (reg_q !== exp_reg_q()) begin
      $display("FAIL async_reset_reg_q got=%h want=%h", reg_q, exp_reg_q());
      bad++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; bready = 1; rready = 1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid || rvalid) stray++;
    end
    bready = 0; rready = 0;
    total++;
    if (stray !== 0) begin
      $display("FAIL stale_response got=%0d cycles want=0", stray);
      bad++;
    end
    axi_write(3'd4, 32'h600D_CAFE, 4'hF, 0, 1, 1, resp, por, pc, bw, st, air, to);
    model[4] = 32'h600D_CAFE;
    axi_read(3'd4, 0, 1, rd, resp, st, to);
    total++;
    if (to !== 1'b0 || rd !== 32'h600D_CAFE || resp !== 2'b00) begin
      $display("FAIL post_reset_rw got=%h/%b want=600dcafe/00", rd, resp);
      bad++;
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < NR; i++) model[i] = '0;
    test_reset();
    test_same_cycle();
    test_partial_strobe();
    test_split_order();
    test_errors();
    test_collision();
    test_random();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
